// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for timer-sharing blocks: FSM encodings and default widths.
package timer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_PRESCALE = 270000;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable generator: one-cycle tick every PRESCALE enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/timer_arbiter.sv
// One prescaled down-counter shared round-robin among NUM_REQ requesters.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_ticks,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         remaining,
  output logic                     tick
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [CNT_W-1:0] pick_ticks;
  logic [IDX_W-1:0] owner_nxt;
  int               idx;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (state == ST_IDLE),
    .en     (state == ST_COUNT),
    .tick   (tick)
  );

  // First set request at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(idx);
      end
    end
    pick_ticks = req_ticks[pick_idx*CNT_W +: CNT_W];
  end

  assign owner_nxt = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      remaining <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner     <= pick_idx;
            grant     <= NUM_REQ'(1) << pick_idx;
            remaining <= pick_ticks;
            busy      <= 1'b1;
            if (pick_ticks == '0) begin
              state <= ST_DONE;
              done  <= NUM_REQ'(1) << pick_idx;
            end else begin
              state <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          // Cancel beats a coinciding final tick: no done for a dropped request.
          if (!req[owner]) begin
            state     <= ST_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            rr_ptr    <= owner_nxt;
          end else if (tick && remaining != '0) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= ST_DONE;
              done  <= grant;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          grant     <= '0;
          busy      <= 1'b0;
          remaining <= '0;
          rr_ptr    <= owner_nxt;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: PRESCALE=4 main instance plus a PRESCALE=1 instance.
module tb_timer_arbiter;

  localparam int NR = 4;
  localparam int CW = 8;

  logic           clk_in = 1'b0;
  logic           rst_n  = 1'b0;
  logic [NR-1:0]  req    = '0;
  logic [NR*CW-1:0] req_ticks = '0;
  logic [NR-1:0]  grant, done;
  logic           busy, tick;
  logic [CW-1:0]  remaining;

  logic [NR-1:0]  req_f = '0;
  logic [NR*CW-1:0] req_ticks_f = '0;
  logic [NR-1:0]  grant_f, done_f;
  logic           busy_f, tick_f;
  logic [CW-1:0]  remaining_f;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_in = ~clk_in;

  timer_arbiter #(.NUM_REQ(NR), .PRESCALE(4), .CNT_W(CW)) u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .req(req), .req_ticks(req_ticks),
    .grant(grant), .done(done), .busy(busy), .remaining(remaining), .tick(tick)
  );

  timer_arbiter #(.NUM_REQ(NR), .PRESCALE(1), .CNT_W(CW)) u_fast (
    .clk_in(clk_in), .rst_n(rst_n), .req(req_f), .req_ticks(req_ticks_f),
    .grant(grant_f), .done(done_f), .busy(busy_f), .remaining(remaining_f), .tick(tick_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    req_f = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_ticks(input int i, input logic [CW-1:0] v);
    req_ticks[i*CW +: CW] = v;
  endtask

  initial begin
    logic [NR-1:0] eg, ed, oh;
    int slot, pos, done_at;
    logic wrap_seen;
    logic [CW-1:0] prev_rem;

    // Reset state
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rem", 32'(remaining), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tick", 32'(tick), 0);
    step();
    rst_n = 1'b1;

    // Single req[1], 3 ticks; non-owner traffic and req_ticks change mid-count
    set_ticks(1, 8'd3);
    req = 4'b0010;
    step();
    chk("t1_grant_c1", 32'(grant), 32'h2);
    chk("t1_rem_c1", 32'(remaining), 3);
    chk("t1_busy_c1", 32'(busy), 1);
    for (int c = 2; c <= 14; c++) begin
      step();
      chk($sformatf("t1_tick_c%0d", c), 32'(tick), (c == 4 || c == 8 || c == 12) ? 1 : 0);
      chk($sformatf("t1_done_c%0d", c), 32'(done), (c == 13) ? 32'h2 : 0);
      if (c == 4) begin req[2] = 1'b1; set_ticks(1, 8'd9); end
      if (c == 7) req[2] = 1'b0;
      if (c == 5)  chk("t1_rem_c5", 32'(remaining), 2);
      if (c == 13) begin
        chk("t1_grant_c13", 32'(grant), 32'h2);
        chk("t1_rem_c13", 32'(remaining), 0);
        req = '0;
      end
      if (c == 14) begin
        chk("t1_grant_c14", 32'(grant), 0);
        chk("t1_busy_c14", 32'(busy), 0);
      end
    end

    // All four requesting, 1 tick each: rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) set_ticks(i, 8'd1);
    req = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      step();
      slot = (c - 1) / 6;
      pos  = (c - 1) % 6;
      oh   = 4'b0001 << (slot % 4);
      eg   = (pos <= 4) ? oh : 4'b0000;
      ed   = (pos == 4) ? oh : 4'b0000;
      chk($sformatf("rr_grant_c%0d", c), 32'(grant), 32'(eg));
      chk($sformatf("rr_done_c%0d", c), 32'(done), 32'(ed));
    end
    req = '0;

    // Zero-delay request
    do_reset();
    set_ticks(2, 8'd0);
    req = 4'b0100;
    step();
    chk("z_grant", 32'(grant), 32'h4);
    chk("z_done", 32'(done), 32'h4);
    req = '0;
    step();
    chk("z_busy_c2", 32'(busy), 0);
    chk("z_done_c2", 32'(done), 0);

    // Cancel: req[0] 5 ticks dropped at cycle 7
    do_reset();
    set_ticks(0, 8'd5);
    set_ticks(1, 8'd0);
    req = 4'b0001;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("cx_done_c%0d", c), 32'(done), 0);
    end
    chk("cx_grant_c7", 32'(grant), 32'h1);
    chk("cx_rem_c7", 32'(remaining), 4);
    req = '0;
    step();
    chk("cx_grant_c8", 32'(grant), 0);
    chk("cx_busy_c8", 32'(busy), 0);
    chk("cx_done_c8", 32'(done), 0);
    chk("cx_rem_c8", 32'(remaining), 0);
    req = 4'b0011;
    step();
    chk("cx_rot_grant1", 32'(grant), 32'h2);
    chk("cx_rot_done1", 32'(done), 32'h2);
    req = 4'b0001;
    step();
    chk("cx_rot_idle", 32'(grant), 0);
    step();
    chk("cx_rot_grant0", 32'(grant), 32'h1);
    req = '0;
    step();

    // Async reset mid-count, then fresh service of req[3]
    do_reset();
    set_ticks(3, 8'd3);
    req = 4'b1000;
    for (int c = 1; c <= 6; c++) step();
    chk("ar_grant_pre", 32'(grant), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_rem", 32'(remaining), 0);
    step();
    chk("ar_done_held", 32'(done), 0);
    rst_n = 1'b1;
    step();
    chk("ar_grant_c1", 32'(grant), 32'h8);
    chk("ar_rem_c1", 32'(remaining), 3);
    for (int c = 2; c <= 13; c++) begin
      step();
      chk($sformatf("ar_done_c%0d", c), 32'(done), (c == 13) ? 32'h8 : 0);
    end
    req = '0;

    // PRESCALE=1, 255 ticks: done at cycle 256, no wrap
    do_reset();
    req_ticks_f[0 +: CW] = 8'd255;
    req_f = 4'b0001;
    done_at   = 0;
    wrap_seen = 1'b0;
    prev_rem  = '0;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (c == 1) chk("f_rem_c1", 32'(remaining_f), 255);
      if (c > 1 && busy_f && remaining_f > prev_rem) wrap_seen = 1'b1;
      prev_rem = remaining_f;
      if (done_f[0] && done_at == 0) begin
        done_at = c;
        chk("f_rem_at_done", 32'(remaining_f), 0);
        req_f = '0;
      end
    end
    chk("f_done_cycle", 32'(done_at), 256);
    chk("f_no_wrap", 32'(wrap_seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
